// File: rtl/stdp_pkg.sv
// Shared constants and FSM encoding for the STDP weight-update path and its stochastic sources.
package stdp_pkg;

    localparam int unsigned P_WIDTH_DEF = 7;

    // Fibonacci LFSR x^7 + x^6 + 1; tap indices are zero-based state bits
    localparam int unsigned LFSR_WIDTH = 7;
    localparam int unsigned LFSR_TAP_A = 6;
    localparam int unsigned LFSR_TAP_B = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROLL  = 2'd1,
        APPLY = 2'd2
    } upd_state_t;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] cur);
        return {cur[LFSR_WIDTH-2:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running 7-bit Fibonacci LFSR; shared by the weight updater and comparator-side sources.
module lfsr_gen
    import stdp_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = 7'h5A
) (
    input  logic                  clk,
    input  logic                  rst_b,
    output logic [LFSR_WIDTH-1:0] o_state
);

    logic [LFSR_WIDTH-1:0] r_state;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/stdp_weight_update.sv
// Bernoulli-gated saturating synaptic weight update. Optional counters under STDP_UPD_STATS_EN.
module stdp_weight_update
    import stdp_pkg::*;
#(
    parameter int unsigned           P_WIDTH   = P_WIDTH_DEF,
    parameter int unsigned           W_WIDTH   = 3,
    parameter logic [W_WIDTH-1:0]    W_INIT    = '0,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = 7'h5A
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [P_WIDTH-1:0] prob,
    input  logic               inc,
    output logic [W_WIDTH-1:0] weight,
    output logic               w_valid,
    output logic               w_hit,
    output logic               w_sat
`ifdef STDP_UPD_STATS_EN
    ,
    output logic [15:0]        stat_trials,
    output logic [15:0]        stat_hits
`endif
);

    upd_state_t            r_state;
    upd_state_t            w_state_nxt;
    logic [P_WIDTH-1:0]    r_prob;
    logic                  r_inc;
    logic [W_WIDTH-1:0]    r_weight;
    logic                  r_valid;
    logic                  r_hit;
    logic                  r_sat;

    logic [LFSR_WIDTH-1:0] w_lfsr;
    logic [P_WIDTH-1:0]    w_lfsr_cmp;
    logic                  w_accept;
    logic                  w_roll_hit;
    logic                  w_at_max;
    logic                  w_at_min;
    logic                  w_at_limit;
    logic [W_WIDTH-1:0]    w_weight_nxt;

    lfsr_gen #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_b   (rst_b),
        .o_state (w_lfsr)
    );

    assign w_lfsr_cmp = P_WIDTH'(w_lfsr);
    assign w_accept   = upd_valid && upd_ready;
    // LFSR never reaches zero, so prob=0 can never hit and prob=all-ones always hits
    assign w_roll_hit = (w_lfsr_cmp <= r_prob);
    assign w_at_max   = (r_weight == {W_WIDTH{1'b1}});
    assign w_at_min   = (r_weight == '0);
    assign w_at_limit = r_inc ? w_at_max : w_at_min;

    always_comb begin
        w_weight_nxt = r_weight;
        if (w_roll_hit && !w_at_limit) begin
            w_weight_nxt = r_inc ? (r_weight + 1'b1) : (r_weight - 1'b1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ROLL;
            ROLL:    w_state_nxt = APPLY;
            APPLY:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_prob <= '0;
            r_inc  <= 1'b0;
        end else if (w_accept) begin
            r_prob <= prob;
            r_inc  <= inc;
        end
    end

    // Result is committed on the ROLL->APPLY edge so all outputs are registered during APPLY
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_weight <= W_INIT;
            r_valid  <= 1'b0;
            r_hit    <= 1'b0;
            r_sat    <= 1'b0;
        end else if (r_state == ROLL) begin
            r_weight <= w_weight_nxt;
            r_valid  <= 1'b1;
            r_hit    <= w_roll_hit;
            r_sat    <= w_roll_hit && w_at_limit;
        end else begin
            r_valid  <= 1'b0;
            r_hit    <= 1'b0;
            r_sat    <= 1'b0;
        end
    end

    assign upd_ready = (r_state == IDLE);
    assign weight    = r_weight;
    assign w_valid   = r_valid;
    assign w_hit     = r_hit;
    assign w_sat     = r_sat;

`ifdef STDP_UPD_STATS_EN
    logic [15:0] r_trials;
    logic [15:0] r_hits;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_trials <= '0;
            r_hits   <= '0;
        end else if (r_state == APPLY) begin
            if (r_trials != 16'hFFFF) r_trials <= r_trials + 16'd1;
            if (r_hit && (r_hits != 16'hFFFF)) r_hits <= r_hits + 16'd1;
        end
    end

    assign stat_trials = r_trials;
    assign stat_hits   = r_hits;
`endif

endmodule

// File: tb/tb_stdp_weight_update.sv
// Directed-vector bench for stdp_weight_update (W_INIT=3); exercises stats under STDP_UPD_STATS_EN.
module tb_stdp_weight_update;

    logic       clk;
    logic       rst_b;
    logic       upd_valid;
    logic       upd_ready;
    logic [6:0] prob;
    logic       inc;
    logic [2:0] weight;
    logic       w_valid;
    logic       w_hit;
    logic       w_sat;
`ifdef STDP_UPD_STATS_EN
    logic [15:0] stat_trials;
    logic [15:0] stat_hits;
`endif

    int n_vec;
    int n_err;

    stdp_weight_update #(
        .P_WIDTH   (7),
        .W_WIDTH   (3),
        .W_INIT    (3'd3),
        .LFSR_SEED (7'h5A)
    ) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .prob        (prob),
        .inc         (inc),
        .weight      (weight),
        .w_valid     (w_valid),
        .w_hit       (w_hit),
        .w_sat       (w_sat)
`ifdef STDP_UPD_STATS_EN
        ,
        .stat_trials (stat_trials),
        .stat_hits   (stat_hits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One request; checks the two-cycle latency and returns the APPLY-cycle outputs
    task automatic do_req(input logic [6:0] p, input logic d,
                          output logic hit, output logic sat, output logic [2:0] wt);
        int lat;
        lat = -1;
        hit = 1'b0;
        sat = 1'b0;
        wt  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (upd_ready) break;
        end
        upd_valid = 1'b1;
        prob      = p;
        inc       = d;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        // Scramble inputs; the in-flight trial must use the captured values
        prob      = ~p;
        inc       = ~d;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (w_valid) begin
                lat = i + 1;
                hit = w_hit;
                sat = w_sat;
                wt  = weight;
                break;
            end
        end
        check("latency", lat, 2);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    logic       h;
    logic       s;
    logic [2:0] wt;
    int         hits;
    int         sats;
    int         vcnt;
    int         vhits;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_b     = 1'b0;
        upd_valid = 1'b0;
        prob      = '0;
        inc       = 1'b0;

        // 1: reset state
        repeat (3) @(negedge clk);
        check("rst_weight", weight, 3);
        check("rst_ready", upd_ready, 1);
        check("rst_wvalid", w_valid, 0);
        check("rst_lfsr", dut.u_lfsr.o_state, 7'h5A);
        release_reset();

        // 2: potentiate to the top and saturate
        for (int k = 0; k < 4; k++) begin
            do_req(7'd127, 1'b1, h, s, wt);
            check("pot_hit", h, 1);
            check("pot_sat", s, 0);
            check("pot_weight", wt, 4 + k);
        end
        do_req(7'd127, 1'b1, h, s, wt);
        check("pot5_hit", h, 1);
        check("pot5_sat", s, 1);
        check("pot5_weight", wt, 7);

        // 3: prob=0 never hits
        hits = 0;
        sats = 0;
        for (int k = 0; k < 200; k++) begin
            do_req(7'd0, 1'b0, h, s, wt);
            hits += int'(h);
            sats += int'(s);
        end
        check("p0_hits", hits, 0);
        check("p0_sats", sats, 0);
        check("p0_weight", weight, 7);

        // 4: depress to zero and saturate without wrapping
        for (int k = 0; k < 6; k++) do_req(7'd127, 1'b0, h, s, wt);
        check("dep_weight1", wt, 1);
        do_req(7'd127, 1'b0, h, s, wt);
        check("dep0_hit", h, 1);
        check("dep0_sat", s, 0);
        check("dep0_weight", wt, 0);
        do_req(7'd127, 1'b0, h, s, wt);
        check("depsat_hit", h, 1);
        check("depsat_sat", s, 1);
        check("depsat_weight", wt, 0);

        // 5: upd_valid held high: one trial per 3 cycles, hit ratio near 1/2
        @(negedge clk);
        check("p64_ready", upd_ready, 1);
        upd_valid = 1'b1;
        prob      = 7'd64;
        inc       = 1'b1;
        vcnt      = 0;
        vhits     = 0;
        for (int c = 0; c < 38100; c++) begin
            if (c != 0) @(negedge clk);
            if (w_valid) begin
                vcnt++;
                vhits += int'(w_hit);
            end
        end
        upd_valid = 1'b0;
        check("p64_trials", vcnt, 12700);
        check("p64_ratio_lo", (vhits >= 6119) && (vhits <= 6881), 1);
        repeat (4) @(negedge clk);
        check("p64_no_extra", w_valid, 0);

        // 6: reset in ROLL aborts the trial
        @(negedge clk);
        upd_valid = 1'b1;
        prob      = 7'd127;
        inc       = 1'b1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        check("roll_ready", upd_ready, 0);
        #2;
        rst_b = 1'b0;
        vcnt  = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vcnt += int'(w_valid);
        end
        check("abort_wvalid", vcnt, 0);
        check("abort_weight", weight, 3);
        check("abort_ready", upd_ready, 1);
        release_reset();

`ifdef STDP_UPD_STATS_EN
        apply_reset();
        check("stat_rst_trials", stat_trials, 0);
        release_reset();
        for (int k = 0; k < 5; k++) do_req(7'd127, 1'b1, h, s, wt);
        @(negedge clk);
        check("stat_trials", stat_trials, 5);
        check("stat_hits", stat_hits, 5);
        apply_reset();
        check("stat_clr_trials", stat_trials, 0);
        check("stat_clr_hits", stat_hits, 0);
        release_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
